// File: rtl/alu_seq_pkg.sv
// Shared encodings for the execution-stage ALU: opcodes, operand-2 select and FSM states.
// The controller drives the same values, so edit both sides together.
package alu_seq_pkg;

  localparam int XLEN = 32;
  localparam int OP_W = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 8'd0;
  localparam logic [OP_W-1:0] OP_ADDI = 8'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 8'd2;
  localparam logic [OP_W-1:0] OP_MUL  = 8'd3;
  localparam logic [OP_W-1:0] OP_DIV  = 8'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 8'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 8'd6;
  localparam logic [OP_W-1:0] OP_AND  = 8'd7;
  localparam logic [OP_W-1:0] OP_OR   = 8'd8;
  localparam logic [OP_W-1:0] OP_NOT  = 8'd9;
  localparam logic [OP_W-1:0] OP_XOR  = 8'd10;
  localparam logic [OP_W-1:0] OP_LUI  = 8'd11;

  localparam logic [1:0] OP2_RS2 = 2'b00;
  localparam logic [1:0] OP2_IMM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } alu_state_e;

  function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? neg_val(v) : v;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Controller-to-ALU bus. The master drives the request fields; the ALU returns result/busy/done.
// Handshake: alu_en is a start request taken only while the ALU is idle (busy=0, done=0); requests
// at other times are dropped. done pulses for one cycle when result becomes valid; result then holds.
interface alu_seq_if;
  logic                                alu_en;
  logic [alu_seq_pkg::OP_W-1:0]        alu_op;
  logic [1:0]                          op2_dir;
  logic [alu_seq_pkg::XLEN-1:0]        rs1_data;
  logic [alu_seq_pkg::XLEN-1:0]        rs2_data;
  logic [alu_seq_pkg::XLEN-1:0]        imm;
  logic [alu_seq_pkg::XLEN-1:0]        result;
  logic                                busy;
  logic                                done;

  modport master (output alu_en, alu_op, op2_dir, rs1_data, rs2_data, imm,
                  input  result, busy, done);
  modport slave  (input  alu_en, alu_op, op2_dir, rs1_data, rs2_data, imm,
                  output result, busy, done);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply (LSB first) and signed restoring divide, one step per cycle.
// o_last is high during the final step; o_result is the value that step produces.
module alu_muldiv_iter
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // r_x: multiplier / dividend-quotient, r_y: multiplicand / divisor, r_acc: product / remainder
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg;
  logic             r_div0;
  logic [XLEN-1:0]  r_x;
  logic [XLEN-1:0]  r_y;
  logic [XLEN-1:0]  r_acc;

  logic [XLEN:0]    w_rem_sh;
  logic [XLEN:0]    w_diff;
  logic [XLEN-1:0]  w_acc_n;
  logic [XLEN-1:0]  w_x_n;
  logic [XLEN-1:0]  w_y_n;

  always_comb begin
    w_rem_sh = {r_acc, r_x[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, r_y};
    w_acc_n  = r_acc;
    w_x_n    = r_x;
    w_y_n    = r_y;
    if (r_is_div) begin
      if (!w_diff[XLEN]) begin
        w_acc_n = w_diff[XLEN-1:0];
        w_x_n   = {r_x[XLEN-2:0], 1'b1};
      end else begin
        w_acc_n = w_rem_sh[XLEN-1:0];
        w_x_n   = {r_x[XLEN-2:0], 1'b0};
      end
    end else begin
      w_acc_n = r_acc + (r_x[0] ? r_y : '0);
      w_x_n   = r_x >> 1;
      w_y_n   = r_y << 1;
    end
  end

  assign o_last = r_run && (r_cnt == LAST_CNT);
  // Divide by zero is forced to all ones regardless of dividend sign
  assign o_result = !r_is_div ? w_acc_n :
                    r_div0    ? '1      :
                    r_neg     ? neg_val(w_x_n) : w_x_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_neg    <= i_op1[XLEN-1] ^ i_op2[XLEN-1];
      r_div0   <= (i_op2 == '0);
      r_x      <= i_is_div ? abs_val(i_op1) : i_op2;
      r_y      <= i_is_div ? abs_val(i_op2) : i_op1;
      r_acc    <= '0;
    end else if (r_run) begin
      r_acc <= w_acc_n;
      r_x   <= w_x_n;
      r_y   <= w_y_n;
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST_CNT) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execution-stage ALU: operand select, single-cycle ops and the top FSM around the iterative MUL/DIV.
// Build option ALU_FAST_MUL_EN: MUL completes combinationally in one cycle instead of iterating.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output alu_state_e  o_dbg_state
);

  alu_state_e       r_state;
  alu_state_e       w_state_n;
  logic [XLEN-1:0]  r_result;
  logic [XLEN-1:0]  w_result_n;
  logic [XLEN-1:0]  w_op1;
  logic [XLEN-1:0]  w_op2;
  logic [XLEN-1:0]  w_single;
  logic             w_iter_start;
  logic             w_iter_last;
  logic [XLEN-1:0]  w_iter_result;
  logic             w_is_mul_iter;

  assign w_op1 = bus.rs1_data;
  assign w_op2 = (bus.op2_dir == OP2_RS2) ? bus.rs2_data :
                 (bus.op2_dir == OP2_IMM) ? bus.imm      : '0;

`ifdef ALU_FAST_MUL_EN
  assign w_is_mul_iter = 1'b0;
`else
  assign w_is_mul_iter = (bus.alu_op == OP_MUL);
`endif

  always_comb begin
    w_single = '0;
    case (bus.alu_op)
      OP_ADD, OP_ADDI: w_single = w_op1 + w_op2;
      OP_SUB:          w_single = w_op1 - w_op2;
      OP_SLL:          w_single = w_op1 << w_op2[4:0];
      OP_SRL:          w_single = w_op1 >> w_op2[4:0];
      OP_AND:          w_single = w_op1 & w_op2;
      OP_OR:           w_single = w_op1 | w_op2;
      OP_NOT:          w_single = ~w_op1;
      OP_XOR:          w_single = w_op1 ^ w_op2;
      OP_LUI:          w_single = w_op2;
`ifdef ALU_FAST_MUL_EN
      OP_MUL:          w_single = w_op1 * w_op2;
`endif
      default:         w_single = '0;
    endcase
  end

  alu_muldiv_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_iter_start),
    .i_is_div (bus.alu_op == OP_DIV),
    .i_op1    (w_op1),
    .i_op2    (w_op2),
    .o_last   (w_iter_last),
    .o_result (w_iter_result)
  );

  // Single-cycle ops register their result on the start edge and go straight to DONE
  always_comb begin
    w_state_n    = r_state;
    w_result_n   = r_result;
    w_iter_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.alu_en) begin
          if (bus.alu_op == OP_DIV) begin
            w_state_n    = ST_DIV_RUN;
            w_iter_start = 1'b1;
          end else if (w_is_mul_iter) begin
            w_state_n    = ST_MUL_RUN;
            w_iter_start = 1'b1;
          end else begin
            w_state_n  = ST_DONE;
            w_result_n = w_single;
          end
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (w_iter_last) begin
          w_state_n  = ST_DONE;
          w_result_n = w_iter_result;
        end
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
    end else begin
      r_state  <= w_state_n;
      r_result <= w_result_n;
    end
  end

  assign bus.result  = r_result;
  assign bus.busy    = (r_state == ST_MUL_RUN) || (r_state == ST_DIV_RUN);
  assign bus.done    = (r_state == ST_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, busy/DONE start rejection, back-to-back start,
// mid-operation reset abort and a short random run, all checked through an expected-result queue.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  alu_state_e dbg_state;

  alu_seq_if bus();

  alu_seq dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [7:0] ABORT_OP = OP_DIV;
`else
  localparam int MUL_LAT = 33;
  localparam logic [7:0] ABORT_OP = OP_MUL;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  dir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller sits on a negedge; alu_en is high across exactly one posedge
  task automatic issue(input logic [7:0] op, input logic [1:0] dir, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] exp,
                       input bit push);
    bus.alu_op   = op;
    bus.op2_dir  = dir;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.imm      = im;
    bus.alu_en   = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    bus.alu_en = 1'b0;
  endtask

  task automatic drive_add_ones();
    bus.alu_op   = OP_ADD;
    bus.op2_dir  = OP2_RS2;
    bus.rs1_data = 32'd1;
    bus.rs2_data = 32'd1;
    bus.alu_en   = 1'b1;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input int intrude_at,
                           input bit intrude_done);
    int          lat;
    int          nbusy;
    bit          seen;
    logic [31:0] held;
    lat   = 1;
    nbusy = 0;
    seen  = 1'b0;
    while (lat <= 100) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) nbusy++;
      if (lat == intrude_at) drive_add_ones();
      else bus.alu_en = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.alu_en = 1'b0;
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_result: got %h, expected queue empty", name, bus.result);
    end else begin
      chk({name, "_result"}, bus.result, exp_q.pop_front());
    end
    held = bus.result;
    if (intrude_done) drive_add_ones();
    @(negedge clk);
    bus.alu_en = 1'b0;
    chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({name, "_result_held"}, bus.result, held);
  endtask

  initial begin
    int          seen_done;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rexp;
    int          rsel;

    bus.alu_en   = 1'b0;
    bus.alu_op   = '0;
    bus.op2_dir  = OP2_RS2;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.imm      = '0;

    repeat (3) @(negedge clk);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    vecs.push_back('{OP_ADDI, OP2_IMM, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd2, 1});
    vecs.push_back('{OP_ADD,  OP2_RS2, 32'd1, 32'd1, 32'd0, 32'd2, 1});
    vecs.push_back('{OP_SUB,  OP2_RS2, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1});
    vecs.push_back('{OP_SLL,  OP2_RS2, 32'd1, 32'd35, 32'd0, 32'h0000_0008, 1});
    vecs.push_back('{OP_SRL,  OP2_RS2, 32'h8000_0000, 32'd31, 32'd0, 32'h0000_0001, 1});
    vecs.push_back('{OP_AND,  OP2_RS2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h00F0_1200, 1});
    vecs.push_back('{OP_OR,   OP2_IMM, 32'hA000_0005, 32'd0, 32'h0000_0F00, 32'hA000_0F05, 1});
    vecs.push_back('{OP_XOR,  OP2_RS2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 32'hF0F0_0F0F, 1});
    vecs.push_back('{OP_NOT,  OP2_RS2, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 32'hEDCB_A987, 1});
    vecs.push_back('{OP_LUI,  OP2_IMM, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'h1234_5000, 1});
    vecs.push_back('{OP_ADD,  2'b01,   32'd9, 32'd100, 32'd77, 32'd9, 1});
    vecs.push_back('{OP_ADD,  2'b11,   32'd9, 32'd100, 32'd77, 32'd9, 1});
    vecs.push_back('{8'd12,   OP2_RS2, 32'd9, 32'd9, 32'd0, 32'd0, 1});
    vecs.push_back('{8'hFF,   OP2_RS2, 32'd9, 32'd9, 32'd0, 32'd0, 1});
    vecs.push_back('{OP_MUL,  OP2_RS2, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFF9, MUL_LAT});
    vecs.push_back('{OP_MUL,  OP2_IMM, 32'h1234_5678, 32'd0, 32'h10, 32'h2345_6780, MUL_LAT});
    vecs.push_back('{OP_DIV,  OP2_RS2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, DIV_LAT});
    vecs.push_back('{OP_DIV,  OP2_RS2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{OP_DIV,  OP2_RS2, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFFF, DIV_LAT});
    vecs.push_back('{OP_DIV,  OP2_RS2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT});
    vecs.push_back('{OP_DIV,  OP2_IMM, 32'd100, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT});

    // Each vector starts on the cycle the previous done falls
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].dir, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].exp, 1'b1);
      wait_done($sformatf("vec%0d", i), vecs[i].lat, 0, 1'b0);
    end

    // ADD 1+1 pulsed mid-DIV and again during DONE must be dropped
    issue(OP_DIV, OP2_RS2, 32'd100, 32'd7, 32'd0, 32'd14, 1'b1);
    wait_done("div_busy_ignore", DIV_LAT, 5, 1'b1);
    issue(OP_ADD, OP2_RS2, 32'd2, 32'd3, 32'd0, 32'd5, 1'b1);
    wait_done("back_to_back", 1, 0, 1'b0);

    // Reset during iteration 10 aborts with no done pulse
    issue(ABORT_OP, OP2_RS2, 32'h0001_2345, 32'h0000_0678, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      ra   = $urandom();
      rb   = $urandom_range(1, 32'h7FFF_FFFF);
      rsel = $urandom_range(0, 3);
      case (rsel)
        0: begin
          rexp = ra + rb;
          issue(OP_ADD, OP2_RS2, ra, rb, 32'd0, rexp, 1'b1);
          wait_done($sformatf("rnd%0d_add", i), 1, 0, 1'b0);
        end
        1: begin
          rexp = ra ^ rb;
          issue(OP_XOR, OP2_IMM, ra, 32'd0, rb, rexp, 1'b1);
          wait_done($sformatf("rnd%0d_xor", i), 1, 0, 1'b0);
        end
        2: begin
          rexp = ra * rb;
          issue(OP_MUL, OP2_RS2, ra, rb, 32'd0, rexp, 1'b1);
          wait_done($sformatf("rnd%0d_mul", i), MUL_LAT, 0, 1'b0);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) rb = (~rb) + 32'd1;
          rexp = 32'($signed(ra) / $signed(rb));
          issue(OP_DIV, OP2_RS2, ra, rb, 32'd0, rexp, 1'b1);
          wait_done($sformatf("rnd%0d_div", i), DIV_LAT, 0, 1'b0);
        end
      endcase
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
